// File: rtl/gray_pkg.sv
// Shared Gray/binary helpers: mode encodings and width-generic conversion functions.
// Purely combinational definitions with no latency and no backpressure involvement.
// Values narrower than 32 bits are zero-extended before they are passed in.
package gray_pkg;

    localparam int   MAX_W    = 32;
    localparam logic MODE_G2B = 1'b0;
    localparam logic MODE_B2G = 1'b1;

    typedef logic [MAX_W-1:0] word_t;

    // The XOR prefix runs from the MSB down. Zero upper bits leave narrower codes unaffected.
    function automatic word_t gray2bin(input word_t g);
        word_t b;
        b[MAX_W-1] = g[MAX_W-1];
        for (int i = MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic word_t bin2gray(input word_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic hamming_gt1(input word_t a, input word_t b);
        word_t d;
        d = a ^ b;
        return (d & (d - word_t'(1))) != '0;
    endfunction

endpackage

// File: rtl/gray_bin_core.sv
// Combinational Gray<->binary converter, direction chosen by mode.
// Zero latency, so it does not take part in flow control.
// Backpressure is handled entirely by the register stages around it.
module gray_bin_core
    import gray_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] data_in,
    input  logic             mode,
    output logic [WIDTH-1:0] data_out
);

    always_comb begin
        data_out = WIDTH'(gray2bin(word_t'(data_in)));
        if (mode == MODE_B2G) begin
            data_out = WIDTH'(bin2gray(word_t'(data_in)));
        end
    end

endmodule

// File: rtl/gray_bin_pipe.sv
// Pipelined Gray<->binary converter with a Gray adjacency checker and a saturating error count.
// Latency is 2 cycles from accept to out_valid, at 1 beat per cycle.
// Each stage loads when it is empty or draining; when stalled the pipe holds 2 beats, then drops in_ready.
module gray_bin_pipe
    import gray_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int CHECK_ADJ = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_mode,
    output logic             adj_err,
    input  logic             clr_err,
    output logic [CNT_W-1:0] err_cnt
);

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_data_q,  s1_data_d;
    logic             s1_mode_q,  s1_mode_d;
    logic             s1_adj_q,   s1_adj_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_data_q,  s2_data_d;
    logic             s2_mode_q,  s2_mode_d;
    logic             s2_adj_q,   s2_adj_d;
    logic [WIDTH-1:0] hist_q,     hist_d;
    logic             hist_vld_q, hist_vld_d;
    logic [CNT_W-1:0] err_cnt_q,  err_cnt_d;

    logic             s2_can_load;
    logic             accept;
    logic             adj_hit;
    logic [WIDTH-1:0] conv_data;

    gray_bin_core #(.WIDTH(WIDTH)) u_core (
        .data_in  (s1_data_q),
        .mode     (s1_mode_q),
        .data_out (conv_data)
    );

    always_comb begin
        s2_can_load = !s2_valid_q | out_ready;
        in_ready    = !s1_valid_q | s2_can_load;
        accept      = in_valid & in_ready;

        adj_hit = 1'b0;
        if (CHECK_ADJ != 0) begin
            adj_hit = accept && (in_mode == MODE_G2B) && hist_vld_q &&
                      hamming_gt1(word_t'(in_data), word_t'(hist_q));
        end

        s1_valid_d = accept | (s1_valid_q & !s2_can_load);
        s1_data_d  = s1_data_q;
        s1_mode_d  = s1_mode_q;
        s1_adj_d   = s1_adj_q;
        if (accept) begin
            s1_data_d = in_data;
            s1_mode_d = in_mode;
            s1_adj_d  = adj_hit;
        end

        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_mode_d  = s2_mode_q;
        s2_adj_d   = s2_adj_q;
        if (s2_can_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d = conv_data;
                s2_mode_d = s1_mode_q;
                s2_adj_d  = s1_adj_q;
            end
        end

        // A clear beats a same-cycle flagged accept: count stays 0 and that beat is not remembered.
        hist_d     = hist_q;
        hist_vld_d = hist_vld_q;
        err_cnt_d  = err_cnt_q;
        if (clr_err) begin
            hist_vld_d = 1'b0;
            err_cnt_d  = '0;
        end else begin
            if (accept && (in_mode == MODE_G2B)) begin
                hist_d     = in_data;
                hist_vld_d = 1'b1;
            end
            if (adj_hit && !(&err_cnt_q)) begin
                err_cnt_d = err_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_mode_q  <= 1'b0;
            s1_adj_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_mode_q  <= 1'b0;
            s2_adj_q   <= 1'b0;
            hist_q     <= '0;
            hist_vld_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_mode_q  <= s1_mode_d;
            s1_adj_q   <= s1_adj_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_mode_q  <= s2_mode_d;
            s2_adj_q   <= s2_adj_d;
            hist_q     <= hist_d;
            hist_vld_q <= hist_vld_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign out_mode  = s2_mode_q;
    assign adj_err   = s2_adj_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_gray_bin_pipe.sv
// Scoreboard bench for gray_bin_pipe (WIDTH=4, CNT_W=2): the driver pushes model results, and the monitor compares them at negedge.
module tb_gray_bin_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       in_mode;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic       out_mode;
    logic       adj_err;
    logic       clr_err;
    logic [1:0] err_cnt;

    gray_bin_pipe #(.WIDTH(4), .CHECK_ADJ(1), .CNT_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_mode  (out_mode),
        .adj_err   (adj_err),
        .clr_err   (clr_err),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] d;
        logic       m;
        logic       a;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       mon_e;
    int         errs   = 0;
    int         checks = 0;
    logic [3:0] m_hist;
    logic       m_hist_v;
    int         m_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] m_g2b(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    function automatic logic [3:0] m_b2g(input logic [3:0] b);
        logic [3:0] g;
        for (int i = 0; i < 4; i++) g[i] = b[i] ^ ((i == 3) ? 1'b0 : b[i+1]);
        return g;
    endfunction

    task automatic send(input logic [3:0] d, input logic m, input logic clr);
        int   n;
        logic flag;
        exp_t e;
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        clr_err  = clr;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            chk("send_timeout", 32'(in_ready), 32'd1);
        end else begin
            flag = (m == 1'b0) && m_hist_v && ($countones(d ^ m_hist) >= 2);
            if (clr) begin
                m_cnt    = 0;
                m_hist_v = 1'b0;
            end else begin
                if (flag && m_cnt < 3) m_cnt++;
                if (m == 1'b0) begin
                    m_hist   = d;
                    m_hist_v = 1'b1;
                end
            end
            e.d = m ? m_b2g(d) : m_g2b(d);
            e.m = m;
            e.a = flag;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clr_err  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("drain", 32'(sb_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // While a beat is presented, it must match the head of the scoreboard, including every stalled cycle.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sb_q.size() == 0) begin
                chk("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                mon_e = sb_q[0];
                chk("out_data", 32'(out_data), 32'(mon_e.d));
                chk("out_mode", 32'(out_mode), 32'(mon_e.m));
                chk("adj_err",  32'(adj_err),  32'(mon_e.a));
                if (out_ready) void'(sb_q.pop_front());
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = 1'b0;
        out_ready = 1'b1;
        clr_err   = 1'b0;
        m_hist    = '0;
        m_hist_v  = 1'b0;
        m_cnt     = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_out_mode",  32'(out_mode),  32'd0);
        chk("rst_adj_err",   32'(adj_err),   32'd0);
        chk("rst_err_cnt",   32'(err_cnt),   32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        @(posedge clk);
        #1;

        send(4'b1101, 1'b0, 1'b0);
        send(4'b1001, 1'b1, 1'b0);
        drain();

        for (int v = 0; v < 16; v++) begin
            send(4'(v), 1'b1, 1'b0);
            send(m_b2g(4'(v)), 1'b0, 1'b0);
        end
        drain();
        chk("sweep_err_cnt", 32'(err_cnt), 32'(m_cnt));

        send(4'b0000, 1'b1, 1'b1);
        send(4'b0000, 1'b0, 1'b0);
        send(4'b0001, 1'b0, 1'b0);
        send(4'b1111, 1'b1, 1'b0);
        send(4'b0011, 1'b0, 1'b0);
        send(4'b0110, 1'b0, 1'b0);
        drain();
        chk("adj_err_cnt", 32'(err_cnt), 32'd1);

        send(4'b0000, 1'b0, 1'b0);
        send(4'b1111, 1'b0, 1'b0);
        send(4'b0000, 1'b0, 1'b0);
        send(4'b1111, 1'b0, 1'b0);
        drain();
        chk("sat_err_cnt", 32'(err_cnt), 32'd3);

        send(4'b0000, 1'b0, 1'b1);
        send(4'b1111, 1'b0, 1'b0);
        drain();
        chk("clr_err_cnt", 32'(err_cnt), 32'd0);

        out_ready = 1'b0;
        send(4'b0001, 1'b0, 1'b0);
        send(4'b0010, 1'b1, 1'b0);
        in_valid = 1'b1;
        in_data  = 4'b0011;
        in_mode  = 1'b0;
        @(negedge clk);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        fork
            begin
                send(4'b0011, 1'b0, 1'b0);
                send(4'b0100, 1'b1, 1'b0);
                send(4'b0111, 1'b0, 1'b0);
            end
        join_none
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait fork;
        drain();

        out_ready = 1'b0;
        send(4'b1010, 1'b0, 1'b0);
        send(4'b0110, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
        sb_q.delete();
        m_hist_v = 1'b0;
        m_cnt    = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
        chk("rst_mid_err_cnt",  32'(err_cnt),  32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        send(4'b0101, 1'b0, 1'b0);
        send(4'b0100, 1'b0, 1'b0);
        drain();
        chk("final_err_cnt", 32'(err_cnt), 32'(m_cnt));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
